gap_layer: RTL and testbench



---
 rtl/gap_pkg.sv | 21 ++
 rtl/gap_accumulator.sv | 44 ++++
 rtl/gap_layer.sv | 85 ++++++++
 tb/tb_gap_layer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gap_pkg.sv
// Shared types and sizing helpers for the global-average-pooling stage.
package gap_pkg;

    // eEMPTY: accumulating samples, eFULL: one averaged result held for the consumer
    typedef enum logic {
        eEMPTY = 1'b0,
        eFULL  = 1'b1
    } gap_state_e;

    // Signed running-sum width: one sample width plus headroom for INPUT_SIZE terms
    function automatic int unsigned gap_acc_width(input int unsigned word_size,
                                                  input int unsigned input_size);
        return word_size + $clog2(input_size) + 1;
    endfunction

    // Sample counter width; counts 0..INPUT_SIZE-1, never narrower than one bit
    function automatic int unsigned gap_cnt_width(input int unsigned input_size);
        return (input_size > 1) ? $clog2(input_size) : 1;
    endfunction

endpackage

// File: rtl/gap_accumulator.sv
// Running sum and sample count for one pooling batch.
module gap_accumulator
    import gap_pkg::*;
#(
    parameter  int unsigned INPUT_SIZE = 5,
    parameter  int unsigned WORD_SIZE  = 16,
    localparam int unsigned ACC_W      = gap_acc_width(WORD_SIZE, INPUT_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    accept_i,
    input  logic [WORD_SIZE-1:0]    data_i,
    output logic signed [ACC_W-1:0] sum_c,
    output logic                    last_c
);

    localparam int unsigned CNT_W = gap_cnt_width(INPUT_SIZE);

    logic [CNT_W-1:0]        count_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] data_ext;

    // Sign-extend the sample and form the sum including the current sample
    assign data_ext = {{(ACC_W - WORD_SIZE){data_i[WORD_SIZE-1]}}, data_i};
    assign sum_c    = acc_q + data_ext;
    assign last_c   = (count_q == CNT_W'(INPUT_SIZE - 1));

    // Accumulate on accept; the batch-completing sample clears both registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            acc_q   <= '0;
        end else if (accept_i) begin
            if (last_c) begin
                count_q <= '0;
                acc_q   <= '0;
            end else begin
                count_q <= count_q + CNT_W'(1);
                acc_q   <= sum_c;
            end
        end
    end

endmodule

// File: rtl/gap_layer.sv
// Global average pooling: averages INPUT_SIZE signed samples into one held result.
module gap_layer
    import gap_pkg::*;
#(
    parameter int unsigned INPUT_SIZE = 5,
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned N_SIZE     = 12
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 ready_o,
    input  logic                 valid_i,
    input  logic [WORD_SIZE-1:0] data_r_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] data_r_o
);

    localparam int unsigned ACC_W = gap_acc_width(WORD_SIZE, INPUT_SIZE);
    localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(INPUT_SIZE);

    // Input and output share one Q format, so the fraction width must leave a sign bit
    if (N_SIZE >= WORD_SIZE) begin : g_bad_format
        $error("gap_layer: N_SIZE must be smaller than WORD_SIZE");
    end

    gap_state_e              state_q, state_d;
    logic [WORD_SIZE-1:0]    data_q, data_d;
    logic                    accept_c;
    logic                    last_c;
    logic signed [ACC_W-1:0] sum_c;
    logic [WORD_SIZE-1:0]    quot_c;

    assign accept_c = valid_i && (state_q == eEMPTY);

    // Constant-divisor signed division truncates toward zero; the quotient always fits
    assign quot_c = WORD_SIZE'(sum_c / DIVISOR);

    gap_accumulator #(
        .INPUT_SIZE (INPUT_SIZE),
        .WORD_SIZE  (WORD_SIZE)
    ) u_acc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .accept_i (accept_c),
        .data_i   (data_r_i),
        .sum_c    (sum_c),
        .last_c   (last_c)
    );

    // Next state: fill on the last accept, drain on the output handshake
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            eEMPTY: begin
                if (accept_c && last_c) begin
                    state_d = eFULL;
                    data_d  = quot_c;
                end
            end
            eFULL: begin
                if (ready_i) begin
                    state_d = eEMPTY;
                end
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eEMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign ready_o  = (state_q == eEMPTY);
    assign valid_o  = (state_q == eFULL);
    assign data_r_o = data_q;

endmodule

// File: tb/tb_gap_layer.sv
// Self-checking bench for gap_layer: directed vector table, corner sequences, random batches.
module tb_gap_layer;

    localparam int unsigned N = 5;
    localparam int unsigned W = 16;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         ready_o;
    logic         valid_i;
    logic [W-1:0] data_r_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_r_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] s [N];
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk_i = ~clk_i;

    gap_layer #(
        .INPUT_SIZE (N),
        .WORD_SIZE  (W),
        .N_SIZE     (12)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .ready_o  (ready_o),
        .valid_i  (valid_i),
        .data_r_i (data_r_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_r_o (data_r_o)
    );

    // Reference average: exact integer sum, magnitude divided, sign restored (truncate toward zero)
    function automatic logic [W-1:0] ref_avg(input int sum);
        int a;
        int q;
        a = (sum < 0) ? -sum : sum;
        q = a / int'(N);
        if (sum < 0) q = -q;
        return W'(q);
    endfunction

    function automatic int sval(input logic [W-1:0] s);
        logic signed [W-1:0] t;
        t = s;
        return int'(t);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        valid_i  = 1'b1;
        data_r_i = d;
        step();
        valid_i  = 1'b0;
        data_r_i = W'($urandom);
    endtask

    task automatic expect_full(input string name, input logic [W-1:0] exp);
        chk({name, "_valid"}, W'(valid_o), W'(1));
        chk({name, "_ready"}, W'(ready_o), W'(0));
        chk({name, "_data"},  data_r_o, exp);
        ready_i = 1'b0;
    endtask

    task automatic drain(input string name);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk({name, "_drain_valid"}, W'(valid_o), W'(0));
        chk({name, "_drain_ready"}, W'(ready_o), W'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, W'(valid_o), W'(0));
        chk({name, "_data"},  data_r_o,    W'(0));
        chk({name, "_ready"}, W'(ready_o), W'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int           sum;
        logic [W-1:0] smp;
        logic [W-1:0] bub [4];

        vecs[0].name = "batch1";
        vecs[0].s    = '{16'h0698, 16'hF105, 16'hF8DD, 16'hF17A, 16'hF31C};
        vecs[0].exp  = 16'hF76A;
        vecs[1].name = "trunc_pos";
        vecs[1].s    = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
        vecs[1].exp  = 16'h0000;
        vecs[2].name = "trunc_neg";
        vecs[2].s    = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2].exp  = 16'h0000;
        vecs[3].name = "max_pos";
        vecs[3].s    = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[3].exp  = 16'h7FFF;
        vecs[4].name = "max_neg";
        vecs[4].s    = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vecs[4].exp  = 16'h8000;
        vecs[5].name = "one_q12";
        vecs[5].s    = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        vecs[5].exp  = 16'h1000;

        reset_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_r_i = '0;

        // Reset asserted between clock edges must act immediately
        #2 reset_i = 1'b1;
        #1 check_reset_outputs("reset_async");
        step();
        step();
        reset_i = 1'b0;
        check_reset_outputs("reset_release");

        // Batch 1 with backpressure: held result ignores input until drained
        for (int j = 0; j < int'(N); j++) push(vecs[0].s[j]);
        expect_full("bp_fill", vecs[0].exp);
        for (int k = 0; k < 3; k++) begin
            valid_i  = 1'b1;
            data_r_i = 16'h7FFF;
            step();
            chk("bp_hold_valid", W'(valid_o), W'(1));
            chk("bp_hold_data",  data_r_o,    16'hF76A);
            chk("bp_hold_ready", W'(ready_o), W'(0));
        end
        valid_i = 1'b0;
        drain("bp");
        for (int j = 0; j < int'(N); j++) push(16'h0000);
        expect_full("bp_ignored", 16'h0000);
        drain("bp_ignored");

        // Table-driven batches, each filled back-to-back and drained
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(N); j++) push(vecs[i].s[j]);
            expect_full(vecs[i].name, vecs[i].exp);
            drain(vecs[i].name);
        end

        // Bubble cycle between the 4th and 5th samples is not counted
        bub = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        sum = 0;
        for (int j = 0; j < 4; j++) begin
            push(bub[j]);
            sum += sval(bub[j]);
        end
        valid_i  = 1'b0;
        data_r_i = 16'h7FFF;
        step();
        chk("bubble_ready", W'(ready_o), W'(1));
        chk("bubble_valid", W'(valid_o), W'(0));
        push(16'hF11A);
        sum += sval(16'hF11A);
        expect_full("bubble", ref_avg(sum));
        drain("bubble");

        // Reset mid-batch discards partial sum and clears the held output word
        for (int j = 0; j < 3; j++) push(16'h7000);
        #3 reset_i = 1'b1;
        #1 check_reset_outputs("reset_midbatch");
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        for (int j = 0; j < int'(N); j++) push(16'h1000);
        expect_full("after_midreset", 16'h1000);
        drain("after_midreset");

        // Reset while a result is pending discards it
        for (int j = 0; j < int'(N); j++) push(16'h2000);
        expect_full("pre_fullreset", 16'h2000);
        #3 reset_i = 1'b1;
        #1 check_reset_outputs("reset_full");
        @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Random batches with bubbles, idle ready_i noise and random drain delay
        for (int b = 0; b < 40; b++) begin
            sum = 0;
            for (int j = 0; j < int'(N); j++) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_i  = 1'b0;
                    data_r_i = W'($urandom);
                    ready_i  = 1'($urandom);
                    step();
                    chk("rnd_empty_ready", W'(ready_o), W'(1));
                end
                case ($urandom_range(0, 3))
                    0:       smp = 16'h7FFF;
                    1:       smp = 16'h8000;
                    default: smp = W'($urandom);
                endcase
                ready_i = 1'($urandom);
                push(smp);
                sum += sval(smp);
            end
            expect_full("rnd", ref_avg(sum));
            repeat ($urandom_range(0, 3)) begin
                valid_i  = 1'($urandom);
                data_r_i = W'($urandom);
                step();
                chk("rnd_hold_valid", W'(valid_o), W'(1));
                chk("rnd_hold_data",  data_r_o,    ref_avg(sum));
            end
            valid_i = 1'b0;
            drain("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
